// File: rtl/pipe_regn_pkg.sv
// Shared constants and helpers for the pipe_regn register pipeline.
package pipe_pkg;

  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 16;

  function automatic int pipe_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int pipe_depth(input int d);
    int r;
    r = d;
    if (d < DEPTH_MIN) r = DEPTH_MIN;
    if (d > DEPTH_MAX) r = DEPTH_MAX;
    return r;
  endfunction

  function automatic int pipe_cw(input int d);
    return pipe_clog2(pipe_depth(d) + 1);
  endfunction

endpackage

// File: rtl/pipe_regn_if.sv
// Upstream/downstream handshake bundle of the pipe_regn pipeline.
interface pipe_regn_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2,
  parameter int DEPTH = 2
);

  localparam int DW = WIDTH * NCH;
  localparam int CW = pipe_cw(DEPTH);

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );

endinterface

// File: rtl/pipe_regn_stage.sv
// One pipeline stage: a valid bit plus NCH*WIDTH data bits.
module pipe_stage #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 load,
  input  logic                 in_valid,
  input  logic [WIDTH*NCH-1:0] in_data,
  output logic                 valid,
  output logic [WIDTH*NCH-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= in_valid;
      end
      // data only moves with a real word, never on flush
      if (!flush && load && in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_regn.sv
// DEPTH-stage valid/ready register pipeline, NCH channels of WIDTH bits.
module pipe_regn
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  pipe_regn_if.slave bus
);

  localparam int DW  = WIDTH * NCH;
  localparam int NST = pipe_depth(DEPTH);
  localparam int CW  = pipe_cw(DEPTH);

  logic          vld [NST];
  logic [DW-1:0] dat [NST];
  logic [NST-1:0] adv;
  logic          full_tail;
  logic          in_rdy;
  logic          acc;
  logic          xfer;
  logic [CW-1:0] cnt;

  // stage i moves iff some stage at or after it is empty, or the sink takes
  always_comb begin
    full_tail = 1'b1;
    adv       = '0;
    for (int i = NST - 1; i >= 0; i--) begin
      full_tail = full_tail & vld[i];
      adv[i]    = bus.out_ready | ~full_tail;
    end
  end

  assign in_rdy = adv[0] & ~bus.flush;
  assign acc    = bus.in_valid & in_rdy;
  assign xfer   = vld[NST-1] & bus.out_ready;

  for (genvar i = 0; i < NST; i++) begin : g_st
    logic          sv;
    logic [DW-1:0] sd;

    if (i == 0) begin : g_head
      assign sv = acc;
      assign sd = bus.in_data;
    end else begin : g_body
      assign sv = vld[i-1];
      assign sd = dat[i-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH),
      .NCH   (NCH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (bus.flush),
      .load     (adv[i]),
      .in_valid (sv),
      .in_data  (sd),
      .valid    (vld[i]),
      .data     (dat[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
    end else if (acc && !xfer) begin
      cnt <= cnt + CW'(1);
    end else if (!acc && xfer) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld[NST-1];
  assign bus.out_data  = dat[NST-1];
  assign bus.count     = cnt;

endmodule

// File: tb/tb_pipe_regn.sv
// Directed and scoreboard checks for pipe_regn at DEPTH 1, 2, 3 and 16.
module tb_pipe_regn;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_regn_if #(.WIDTH(8), .NCH(2), .DEPTH(2))  b2 ();
  pipe_regn_if #(.WIDTH(8), .NCH(2), .DEPTH(3))  b3 ();
  pipe_regn_if #(.WIDTH(8), .NCH(2), .DEPTH(1))  b1 ();
  pipe_regn_if #(.WIDTH(8), .NCH(2), .DEPTH(16)) b16 ();

  pipe_regn #(.WIDTH(8), .NCH(2), .DEPTH(2))
    u2 (.clk(clk), .reset(reset), .bus(b2.slave));
  pipe_regn #(.WIDTH(8), .NCH(2), .DEPTH(3))
    u3 (.clk(clk), .reset(reset), .bus(b3.slave));
  pipe_regn #(.WIDTH(8), .NCH(2), .DEPTH(1))
    u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  pipe_regn #(.WIDTH(8), .NCH(2), .DEPTH(16))
    u16 (.clk(clk), .reset(reset), .bus(b16.slave));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    b2.flush = 0; b2.in_valid = 0; b2.in_data = 0; b2.out_ready = 0;
    b3.flush = 0; b3.in_valid = 0; b3.in_data = 0; b3.out_ready = 0;
    b1.flush = 0; b1.in_valid = 0; b1.in_data = 0; b1.out_ready = 0;
    b16.flush = 0; b16.in_valid = 0; b16.in_data = 0; b16.out_ready = 0;
    #2;
    checks++;
    if (b2.out_valid !== 1'b0 || b2.out_data !== 16'h0 || b2.count !== 2'd0) begin
      errors++;
      $display("FAIL rst_state got v=%b d=%h c=%0d want 0 0 0",
               b2.out_valid, b2.out_data, b2.count);
    end
    checks++;
    if (b2.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready got %b want 1", b2.in_ready);
    end
    b2.flush = 1'b1;
    #1;
    checks++;
    if (b2.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_flush_ready got %b want 0", b2.in_ready);
    end
    b2.flush = 1'b0;
    cyc;
    cyc;
    checks++;
    if (b16.count !== 5'd0 || b16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_d16 got c=%0d v=%b want 0 0", b16.count, b16.out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    cyc;
  endtask

  task automatic test_stream;
    b2.out_ready = 1; b2.in_valid = 1; b2.in_data = 16'h0102;
    cyc;
    checks++;
    if (b2.out_valid !== 1'b0 || b2.count !== 2'd1) begin
      errors++;
      $display("FAIL stream_c1 got v=%b c=%0d want 0 1", b2.out_valid, b2.count);
    end
    b2.in_data = 16'h0304;
    cyc;
    checks++;
    if (b2.out_valid !== 1'b1 || b2.out_data !== 16'h0102 || b2.count !== 2'd2) begin
      errors++;
      $display("FAIL stream_c2 got v=%b d=%h c=%0d want 1 0102 2",
               b2.out_valid, b2.out_data, b2.count);
    end
    b2.in_data = 16'h0506;
    cyc;
    checks++;
    if (b2.out_valid !== 1'b1 || b2.out_data !== 16'h0304 || b2.count !== 2'd2) begin
      errors++;
      $display("FAIL stream_c3 got v=%b d=%h c=%0d want 1 0304 2",
               b2.out_valid, b2.out_data, b2.count);
    end
    b2.in_valid = 0;
    cyc;
    checks++;
    if (b2.out_valid !== 1'b1 || b2.out_data !== 16'h0506 || b2.count !== 2'd1) begin
      errors++;
      $display("FAIL stream_c4 got v=%b d=%h c=%0d want 1 0506 1",
               b2.out_valid, b2.out_data, b2.count);
    end
    cyc;
    checks++;
    if (b2.out_valid !== 1'b0 || b2.count !== 2'd0) begin
      errors++;
      $display("FAIL stream_c5 got v=%b c=%0d want 0 0", b2.out_valid, b2.count);
    end
  endtask

  task automatic test_backpressure;
    b3.out_ready = 0; b3.in_valid = 1; b3.in_data = 16'h1111;
    cyc;
    b3.in_data = 16'h2222;
    cyc;
    b3.in_data = 16'h3333;
    cyc;
    checks++;
    if (b3.count !== 2'd3 || b3.out_valid !== 1'b1 || b3.out_data !== 16'h1111) begin
      errors++;
      $display("FAIL bp_full got c=%0d v=%b d=%h want 3 1 1111",
               b3.count, b3.out_valid, b3.out_data);
    end
    b3.in_data = 16'h4444;
    #1;
    checks++;
    if (b3.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready got %b want 0", b3.in_ready);
    end
    cyc;
    checks++;
    if (b3.count !== 2'd3 || b3.out_data !== 16'h1111) begin
      errors++;
      $display("FAIL bp_hold got c=%0d d=%h want 3 1111", b3.count, b3.out_data);
    end
    b3.out_ready = 1;
    #1;
    checks++;
    if (b3.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_rdy got %b want 1", b3.in_ready);
    end
    cyc;
    b3.in_valid = 0;
    checks++;
    if (b3.out_data !== 16'h2222 || b3.count !== 2'd3) begin
      errors++;
      $display("FAIL bp_w2 got d=%h c=%0d want 2222 3", b3.out_data, b3.count);
    end
    cyc;
    checks++;
    if (b3.out_data !== 16'h3333 || b3.count !== 2'd2) begin
      errors++;
      $display("FAIL bp_w3 got d=%h c=%0d want 3333 2", b3.out_data, b3.count);
    end
    cyc;
    checks++;
    if (b3.out_data !== 16'h4444 || b3.out_valid !== 1'b1 || b3.count !== 2'd1) begin
      errors++;
      $display("FAIL bp_w4 got d=%h v=%b c=%0d want 4444 1 1",
               b3.out_data, b3.out_valid, b3.count);
    end
    cyc;
    checks++;
    if (b3.out_valid !== 1'b0 || b3.count !== 2'd0) begin
      errors++;
      $display("FAIL bp_empty got v=%b c=%0d want 0 0", b3.out_valid, b3.count);
    end
  endtask

  task automatic test_flush;
    b2.out_ready = 0; b2.in_valid = 1; b2.in_data = 16'h0A0A;
    cyc;
    b2.in_data = 16'h0B0B;
    cyc;
    checks++;
    if (b2.count !== 2'd2 || b2.out_data !== 16'h0A0A) begin
      errors++;
      $display("FAIL fl_fill got c=%0d d=%h want 2 0a0a", b2.count, b2.out_data);
    end
    b2.flush = 1; b2.in_data = 16'hEEEE;
    #1;
    checks++;
    if (b2.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fl_in_ready got %b want 0", b2.in_ready);
    end
    cyc;
    b2.flush = 0; b2.in_valid = 0;
    checks++;
    if (b2.out_valid !== 1'b0 || b2.count !== 2'd0 || b2.out_data !== 16'h0A0A) begin
      errors++;
      $display("FAIL fl_clear got v=%b c=%0d d=%h want 0 0 0a0a",
               b2.out_valid, b2.count, b2.out_data);
    end
    b2.out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      cyc;
      checks++;
      if (b2.out_valid !== 1'b0 || b2.count !== 2'd0) begin
        errors++;
        $display("FAIL fl_absent got v=%b c=%0d want 0 0", b2.out_valid, b2.count);
      end
    end
  endtask

  task automatic test_simultaneous;
    b2.out_ready = 1; b2.in_valid = 1; b2.in_data = 16'h1111;
    cyc;
    b2.in_data = 16'h2222;
    cyc;
    b2.in_data = 16'h3333;
    #1;
    checks++;
    if (b2.in_ready !== 1'b1 || b2.count !== 2'd2) begin
      errors++;
      $display("FAIL sim_pre got r=%b c=%0d want 1 2", b2.in_ready, b2.count);
    end
    cyc;
    b2.in_valid = 0;
    checks++;
    if (b2.count !== 2'd2 || b2.out_data !== 16'h2222 || b2.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sim_edge got c=%0d d=%h v=%b want 2 2222 1",
               b2.count, b2.out_data, b2.out_valid);
    end
    cyc;
    checks++;
    if (b2.out_data !== 16'h3333 || b2.count !== 2'd1) begin
      errors++;
      $display("FAIL sim_tail got d=%h c=%0d want 3333 1", b2.out_data, b2.count);
    end
    cyc;
  endtask

  task automatic test_async_reset;
    b2.out_ready = 0; b2.in_valid = 1; b2.in_data = 16'h5A5A;
    cyc;
    b2.in_data = 16'h6B6B;
    cyc;
    b2.in_valid = 0;
    checks++;
    if (b2.count !== 2'd2) begin
      errors++;
      $display("FAIL ar_fill got c=%0d want 2", b2.count);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (b2.out_valid !== 1'b0 || b2.out_data !== 16'h0 || b2.count !== 2'd0) begin
      errors++;
      $display("FAIL ar_clear got v=%b d=%h c=%0d want 0 0 0",
               b2.out_valid, b2.out_data, b2.count);
    end
    #1;
    reset = 1'b0;
    cyc;
    b2.out_ready = 1; b2.in_valid = 1; b2.in_data = 16'hAA55;
    cyc;
    b2.in_valid = 0;
    checks++;
    if (b2.out_valid !== 1'b0 || b2.count !== 2'd1) begin
      errors++;
      $display("FAIL ar_accept got v=%b c=%0d want 0 1", b2.out_valid, b2.count);
    end
    cyc;
    checks++;
    if (b2.out_valid !== 1'b1 || b2.out_data !== 16'hAA55) begin
      errors++;
      $display("FAIL ar_exit got v=%b d=%h want 1 aa55", b2.out_valid, b2.out_data);
    end
    cyc;
    checks++;
    if (b2.out_valid !== 1'b0 || b2.count !== 2'd0) begin
      errors++;
      $display("FAIL ar_drain got v=%b c=%0d want 0 0", b2.out_valid, b2.count);
    end
  endtask

  task automatic test_sweep;
    logic [15:0] q1[$];
    logic [15:0] q16[$];
    logic [15:0] seq;
    logic [15:0] exp;
    int          pr;
    seq = 16'h0100;
    for (int c = 0; c < 1520; c++) begin
      pr = (c < 500) ? 25 : (c < 1000) ? 75 : 50;
      if (c >= 1500) begin
        b1.in_valid = 0; b16.in_valid = 0;
        b1.out_ready = 1; b16.out_ready = 1;
      end else begin
        b1.in_valid  = ($urandom_range(0, 99) < 70);
        b16.in_valid = b1.in_valid;
        b1.out_ready  = ($urandom_range(0, 99) < pr);
        b16.out_ready = ($urandom_range(0, 99) < pr);
      end
      b1.in_data = seq; b16.in_data = seq;
      seq = seq + 16'd1;
      #1;
      checks++;
      if (int'(b1.count) != q1.size() || b1.count > 1'd1) begin
        errors++;
        $display("FAIL sw1_count got %0d want %0d", b1.count, q1.size());
      end
      checks++;
      if (int'(b16.count) != q16.size() || b16.count > 5'd16) begin
        errors++;
        $display("FAIL sw16_count got %0d want %0d", b16.count, q16.size());
      end
      if (b1.out_valid && b1.out_ready) begin
        checks++;
        exp = (q1.size() > 0) ? q1.pop_front() : 16'hxxxx;
        if (b1.out_data !== exp) begin
          errors++;
          $display("FAIL sw1_data got %h want %h", b1.out_data, exp);
        end
      end
      if (b16.out_valid && b16.out_ready) begin
        checks++;
        exp = (q16.size() > 0) ? q16.pop_front() : 16'hxxxx;
        if (b16.out_data !== exp) begin
          errors++;
          $display("FAIL sw16_data got %h want %h", b16.out_data, exp);
        end
      end
      if (b1.in_valid && b1.in_ready) q1.push_back(b1.in_data);
      if (b16.in_valid && b16.in_ready) q16.push_back(b16.in_data);
      cyc;
    end
    checks++;
    if (q1.size() != 0 || q16.size() != 0) begin
      errors++;
      $display("FAIL sw_drain got %0d/%0d left want 0/0", q1.size(), q16.size());
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_flush;
    test_simultaneous;
    test_async_reset;
    test_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_regn.md
PIPE_REGN -- requirements
Module: pipe_regn

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the bit width of one channel.
REQ-002 SHALL have parameter NCH, default 2, meaning the number of parallel channels per stage.
REQ-003 SHALL have parameter DEPTH, default 2, meaning the number of pipeline stages (legal range 1..16).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have port flush, input, 1 bit, a synchronous clear of all stage valid bits.
REQ-007 SHALL have port in_valid, input, 1 bit, meaning the upstream word is present.
REQ-008 SHALL have port in_ready, output, 1 bit, meaning stage 0 accepts this cycle.
REQ-009 SHALL have port in_data, input, NCH*WIDTH bits; channel k is at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid, output, 1 bit, equal to the last stage's valid bit.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning downstream accepts this cycle.
REQ-012 SHALL have port out_data, output, NCH*WIDTH bits, equal to the last stage's data register.
REQ-013 SHALL have port count, output, CW bits with CW = clog2(DEPTH+1), giving the number of valid stages.

Function
REQ-014 SHALL implement DEPTH registered stages; each stage holds a valid bit and NCH*WIDTH data bits.
REQ-015 SHALL mark stage i (i < DEPTH-1) as able to advance when its valid bit is 0 or stage i+1 is able to advance; the last stage can advance when its valid bit is 0 or out_ready=1.
REQ-016 SHALL drive in_ready = (stage 0 able to advance) AND NOT flush, combinationally.
REQ-017 SHALL load stage i+1 with stage i's data and valid on an edge where stage i+1 can advance; stage 0 loads in_data and valid=(in_valid AND in_ready).
REQ-018 SHALL hold the data register of a stage that cannot advance; the data register SHALL update only when its stage loads a valid word.
REQ-019 SHALL give a latency of exactly DEPTH cycles from acceptance to out_valid when out_ready stays 1, and SHALL sustain one word per cycle.
REQ-020 SHALL complete a transfer only on an edge with out_valid=1 and out_ready=1; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 SHALL preserve word order, and SHALL never drop or duplicate a word outside flush or reset.
REQ-022 SHALL clear every valid bit on an edge with flush=1; a word presented that cycle SHALL NOT be accepted, and data registers SHALL hold their values.
REQ-023 SHALL register count, which SHALL change by +1 on accept-only, by -1 on transfer-only, stay unchanged on accept-and-transfer, and go to 0 on flush.
REQ-024 SHALL behave identically for all NCH channels; channels SHALL share the same valid and ready.

Reset
REQ-025 SHALL, on reset=1, immediately clear all valid bits, all data registers and count to 0, independent of clk.
REQ-026 SHALL, while reset=1, drive out_valid=0, out_data=0 and count=0; in_ready SHALL be 1 unless flush=1.
REQ-027 SHALL discard in-flight words when reset is asserted mid-operation; the first edge after release SHALL behave as from empty.

Structure
REQ-028 SHALL place the clog2 count-width function and the DEPTH legal-range constants in the shared package pipe_pkg.
REQ-029 SHALL use one sub-module, pipe_stage (parameters WIDTH and NCH), instantiated DEPTH times in a generate loop.
REQ-030 SHALL contain no latches and no combinational path from in_valid to out_valid.

Verification
REQ-031 Streaming: DEPTH=2, WIDTH=8, NCH=2, out_ready=1, feed 0x0102, 0x0304, 0x0506 on consecutive cycles -> out_data shows the same values from cycle 2, back-to-back, count=2 in steady state.
REQ-032 Backpressure: DEPTH=3, out_ready=0, push 4 words -> in_ready=0 after 3 accepts, count=3, out_data holds the first word; set out_ready=1 -> all 4 words arrive in order.
REQ-033 Flush: pipe full (count=2), flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, incoming word absent from the output.
REQ-034 Async reset: assert reset between clock edges while count=2 -> out_valid, out_data and count are 0 before the next edge; after release, 0xAA55 is accepted and exits after DEPTH cycles.
REQ-035 Simultaneous: full pipe, out_ready=1, in_valid=1 -> accept and transfer occur on the same edge, count unchanged, in_ready=1.
REQ-036 Parameter sweep: DEPTH=1 and DEPTH=16, random valid/ready traffic against a FIFO scoreboard -> no loss, no duplication, count never exceeds DEPTH.
